// File: rtl/pwm_axi_lite_slave.sv
// AXI4-Lite register slave (CTRL/PERIOD/DUTY/SCRATCH) driving a shadow-buffered PWM output.
// Define PWM_IRQ_EN to add the sticky period interrupt output irq.
module pwm_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            period_tick
`ifdef PWM_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1.
  // Masters hold VALID and payload until then; this slave holds B/R VALID and RDATA until READY.
  logic          awready_q, awready_d;
  logic          bvalid_q, bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];

  logic          wr_en, rd_en;
  logic [1:0]    waddr, raddr;

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] per_sh_q, per_sh_d;
  logic [DW-1:0] duty_sh_q, duty_sh_d;
  logic          pwm_q, pwm_d;
  logic          tick_q, tick_d;
  logic          enable, polarity;

  assign waddr    = S_AXI_AWADDR[3:2];
  assign raddr    = S_AXI_ARADDR[3:2];
  assign wr_en    = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en    = arready_q & S_AXI_ARVALID;
  assign enable   = regs_q[0][0];
  assign polarity = regs_q[0][1];

  always_comb begin
    awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
    bvalid_d  = bvalid_q;
    if (wr_en)
      bvalid_d = 1'b1;
    else if (bvalid_q && S_AXI_BREADY)
      bvalid_d = 1'b0;

    regs_d = regs_q;
    if (wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (S_AXI_WSTRB[b])
          regs_d[waddr][b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
      end
    end

    arready_d = S_AXI_ARVALID && !arready_q && !rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[raddr];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // A zero shadow period keeps reloading so a later non-zero PERIOD can take effect.
  always_comb begin
    cnt_d     = cnt_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    tick_d    = 1'b0;
    pwm_d     = polarity;
    if (!enable || per_sh_q == '0) begin
      cnt_d     = '0;
      per_sh_d  = regs_q[1];
      duty_sh_d = regs_q[2];
    end else if (cnt_q == per_sh_q - 32'd1) begin
      cnt_d     = '0;
      per_sh_d  = regs_q[1];
      duty_sh_d = regs_q[2];
      tick_d    = 1'b1;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    if (enable && per_sh_q != '0)
      pwm_d = (cnt_q < duty_sh_q) ^ polarity;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      cnt_q     <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
      tick_q    <= tick_d;
    end
  end

`ifdef PWM_IRQ_EN
  logic irq_q, irq_d;

  // A CTRL write clears the flag even if a tick sets it on the same edge.
  always_comb begin
    irq_d = irq_q;
    if (tick_d && regs_q[0][2])
      irq_d = 1'b1;
    if (wr_en && waddr == 2'd0)
      irq_d = 1'b0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)
      irq_q <= 1'b0;
    else
      irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign pwm_out       = pwm_q;
  assign period_tick   = tick_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_pwm_axi_lite_slave.sv
// Testbench for pwm_axi_lite_slave: AXI register access against a register model,
// PWM waveform checked per period window; irq scenario when PWM_IRQ_EN is defined.
module tb_pwm_axi_lite_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        pwm_out, period_tick;
`ifdef PWM_IRQ_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [4];
  logic [31:0] exp_q [$];
  bit          pwm_log [$];
  bit          tick_log [$];
  int          win_start [32];
  int          win_len [32];
  int          win_ones [32];
  int          n_win, n_ticks, wr_idx;

  always #5 clk = ~clk;

  pwm_axi_lite_slave dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick)
`ifdef PWM_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output bit ok);
    int k = 0;
    logic [31:0] mask = '0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge clk); k++; end while (!awready && k < 20);
    n_cmp++;
    ok = awready && wready;
    if (!ok) begin
      n_err++;
      $display("FAIL wr_accept addr=%h awready=%b wready=%b required 1/1", a, awready, wready);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int b = 0; b < 4; b++) if (s[b]) mask[b*8 +: 8] = 8'hFF;
    model[a[3:2]] = (model[a[3:2]] & ~mask) | (d & mask);
  endtask

  task automatic finish_write();
    int k = 0;
    bready = 1'b1;
    do begin @(negedge clk); k++; end while (!bvalid && k < 20);
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_err++;
      $display("FAIL wr_resp bvalid=%b bresp=%b required 1/00", bvalid, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL wr_resp_drop bvalid=%b required 0", bvalid);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    start_write(a, d, s, ok);
    if (ok) finish_write();
  endtask

  task automatic start_read(input logic [3:0] a, output bit ok);
    int k = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); k++; end while (!arready && k < 20);
    n_cmp++;
    ok = arready;
    if (!ok) begin
      n_err++;
      $display("FAIL rd_accept addr=%h arready=%b required 1", a, arready);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic finish_read(output logic [31:0] d, output bit ok);
    int k = 0;
    rready = 1'b1;
    do begin @(negedge clk); k++; end while (!rvalid && k < 20);
    n_cmp++;
    ok = rvalid && (rresp === 2'b00);
    d = rdata;
    if (!ok) begin
      n_err++;
      $display("FAIL rd_resp rvalid=%b rresp=%b required 1/00", rvalid, rresp);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_resp_drop rvalid=%b required 0", rvalid);
    end
  endtask

  task automatic axi_read_check(input logic [3:0] a, input string name);
    logic [31:0] got, exp;
    bit ok;
    exp_q.push_back(model[a[3:2]]);
    start_read(a, ok);
    if (ok) finish_read(got, ok);
    exp = exp_q.pop_front();
    if (ok) begin
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s addr=%h got=%h required=%h", name, a, got, exp);
      end
    end
  endtask

  task automatic capture(input int n);
    pwm_log.delete();
    tick_log.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_log.push_back(pwm_out);
      tick_log.push_back(period_tick);
    end
  endtask

  // Splits the captured trace into full windows between consecutive ticks.
  task automatic split_windows();
    int last = -1;
    n_win = 0;
    n_ticks = 0;
    for (int i = 0; i < tick_log.size(); i++) begin
      if (tick_log[i]) begin
        n_ticks++;
        if (last >= 0 && n_win < 32) begin
          win_start[n_win] = last;
          win_len[n_win]   = i - last;
          win_ones[n_win]  = 0;
          for (int j = last; j < i; j++) win_ones[n_win] += int'(pwm_log[j]);
          n_win++;
        end
        last = i;
      end
    end
  endtask

  function automatic int ones_in_log();
    int c = 0;
    foreach (pwm_log[i]) c += int'(pwm_log[i]);
    return c;
  endfunction

  task automatic wait_tick(output bit ok);
    int k = 0;
    do begin @(negedge clk); k++; end while (!period_tick && k < 60);
    ok = period_tick;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL tick_timeout period_tick=%b required 1 within 60 cycles", period_tick);
    end
  endtask

  task automatic pwm_config(input logic [31:0] ctrl, input logic [31:0] per,
                            input logic [31:0] duty);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, per, 4'hF);
    axi_write(4'h8, duty, 4'hF);
    axi_write(4'h0, ctrl, 4'hF);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    model = '{default: '0};
    idle(3);
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid, pwm_out, period_tick} !== 7'b0 ||
        rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs ready/valid/pwm/tick=%b rdata=%h required all 0",
               {awready, wready, bvalid, arready, rvalid, pwm_out, period_tick}, rdata);
    end
`ifdef PWM_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq irq=%b required 0", irq);
    end
`endif
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) axi_read_check(4'(i * 4), "reset_reg");
  endtask

  task automatic test_readback();
    logic [31:0] vals [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), vals[i], 4'hF);
      axi_read_check(4'(i * 4), "readback");
    end
  endtask

  task automatic test_strobe();
    axi_write(4'hC, 32'h00000000, 4'hF);
    axi_write(4'hC, 32'hFFFFFFFF, 4'b0101);
    axi_read_check(4'hC, "strobe");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      axi_write(4'($urandom_range(0, 3) * 4), $urandom, 4'($urandom_range(0, 15)));
      axi_read_check(4'($urandom_range(0, 3) * 4), "random");
    end
  endtask

  task automatic test_back_to_back();
    bit okw, okr;
    logic [31:0] got, exp;
    exp_q.push_back(model[3]);
    fork
      start_write(4'hC, $urandom, 4'hF, okw);
      start_read(4'hC, okr);
    join
    if (okw) finish_write();
    if (okr) finish_read(got, okr);
    exp = exp_q.pop_front();
    if (okr) begin
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL same_cycle_rw got=%h required old value %h", got, exp);
      end
    end
    axi_read_check(4'hC, "after_same_cycle_rw");
  endtask

  task automatic test_pwm_basic();
    for (int pol = 0; pol < 2; pol++) begin
      if (pol == 0) pwm_config(32'h1, 32'd10, 32'd3);
      else axi_write(4'h0, 32'h3, 4'hF);
      idle(3);
      capture(45);
      split_windows();
      n_cmp++;
      if (n_win < 3) begin
        n_err++;
        $display("FAIL pwm_windows pol=%0d windows=%0d required >=3", pol, n_win);
      end
      for (int w = 0; w < n_win; w++) begin
        n_cmp++;
        if (win_len[w] !== 10 || win_ones[w] !== (pol ? 7 : 3)) begin
          n_err++;
          $display("FAIL pwm_period pol=%0d len=%0d ones=%0d required 10/%0d",
                   pol, win_len[w], win_ones[w], pol ? 7 : 3);
        end
      end
    end
  endtask

  task automatic test_duty_update();
    bit ok;
    int exp;
    pwm_config(32'h1, 32'd10, 32'd3);
    idle(2);
    fork
      capture(60);
      begin
        wait_tick(ok);
        axi_write(4'h8, 32'd6, 4'hF);
        wr_idx = pwm_log.size();
      end
    join
    split_windows();
    n_cmp++;
    if (n_win < 4) begin
      n_err++;
      $display("FAIL duty_update_windows windows=%0d required >=4", n_win);
    end
    for (int w = 0; w < n_win; w++) begin
      exp = (win_start[w] < wr_idx) ? 3 : 6;
      n_cmp++;
      if (win_len[w] !== 10 || win_ones[w] !== exp) begin
        n_err++;
        $display("FAIL duty_update start=%0d len=%0d ones=%0d required 10/%0d",
                 win_start[w], win_len[w], win_ones[w], exp);
      end
    end
  endtask

  task automatic test_pwm_edges();
    int ones;
    // DUTY above PERIOD: constant active level, ticks continue.
    pwm_config(32'h1, 32'd10, 32'd12);
    idle(3);
    capture(30);
    split_windows();
    ones = ones_in_log();
    n_cmp++;
    if (ones !== 30 || n_ticks < 2) begin
      n_err++;
      $display("FAIL duty_over_period ones=%0d ticks=%0d required 30/>=2", ones, n_ticks);
    end
    // DUTY zero: constant inactive level.
    pwm_config(32'h1, 32'd10, 32'd0);
    idle(3);
    capture(30);
    split_windows();
    ones = ones_in_log();
    n_cmp++;
    if (ones !== 0 || n_ticks < 2) begin
      n_err++;
      $display("FAIL duty_zero ones=%0d ticks=%0d required 0/>=2", ones, n_ticks);
    end
    // PERIOD zero: no ticks, output at polarity.
    pwm_config(32'h1, 32'd0, 32'd3);
    idle(3);
    capture(30);
    split_windows();
    ones = ones_in_log();
    n_cmp++;
    if (ones !== 0 || n_ticks !== 0) begin
      n_err++;
      $display("FAIL period_zero ones=%0d ticks=%0d required 0/0", ones, n_ticks);
    end
    // Disabled with polarity set: output held at 1, no ticks.
    pwm_config(32'h2, 32'd10, 32'd3);
    idle(3);
    capture(30);
    split_windows();
    ones = ones_in_log();
    n_cmp++;
    if (ones !== 30 || n_ticks !== 0) begin
      n_err++;
      $display("FAIL disabled_pol ones=%0d ticks=%0d required 30/0", ones, n_ticks);
    end
  endtask

  task automatic test_hold_reset();
    bit okw, okr;
    logic [31:0] rexp;
    bready = 1'b0;
    rready = 1'b0;
    start_write(4'hC, $urandom, 4'hF, okw);
    rexp = model[1];
    start_read(4'h4, okr);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== rexp || bresp !== 2'b00) begin
        n_err++;
        $display("FAIL hold cycle=%0d bvalid=%b rvalid=%b rdata=%h required 1/1/%h",
                 i, bvalid, rvalid, rdata, rexp);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bvalid, rvalid, awready, arready} !== 4'b0 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_abort bvalid/rvalid/awready/arready=%b rdata=%h required 0",
               {bvalid, rvalid, awready, arready}, rdata);
    end
    model = '{default: '0};
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    axi_read_check(4'hC, "post_reset_scratch");
    axi_read_check(4'h4, "post_reset_period");
  endtask

`ifdef PWM_IRQ_EN
  task automatic test_irq();
    bit ok;
    pwm_config(32'h5, 32'd4, 32'd1);
    wait_tick(ok);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set irq=%b required 1", irq);
    end
    idle(6);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_sticky irq=%b required 1", irq);
    end
    start_write(4'h0, 32'h5, 4'hF, ok);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear irq=%b required 0", irq);
    end
    if (ok) finish_write();
    wait_tick(ok);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_reset irq=%b required 1", irq);
    end
    axi_read_check(4'h0, "irq_ctrl_readback");
  endtask
`endif

  initial begin
    test_reset();
    test_readback();
    test_strobe();
    test_random();
    test_back_to_back();
    test_pwm_basic();
    test_duty_update();
    test_pwm_edges();
`ifdef PWM_IRQ_EN
    test_irq();
`endif
    test_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_axi_lite_slave.md
Name: pwm_axi_lite_slave

Overview:
- AXI4-Lite responder (slave) for the PWM core: decodes master write/read transactions into four 32-bit registers and drives a registered PWM output.
- Sits between the AXI interconnect (master_0 in block designs) and the board pin.
- Replaces the generic slave template so that readback matches writes byte-exact and register changes are glitch-free.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus and register width (only 32 supported).
- C_S_AXI_ADDR_WIDTH, 4, byte address width; word select = addr[3:2].

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address accept.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data accept.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response accept.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address accept.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data accept.
- pwm_out  out  1  registered PWM waveform.
- period_tick  out  1  one-cycle pulse on counter wrap.

Behaviour:
- Reset (async assert, sync release): all READY/VALID = 0, RDATA = 0, all registers = 0, counter = 0, pwm_out = 0, period_tick = 0.
- Register map, all R/W with full 32-bit readback:
  - 0x0 CTRL: [0] enable, [1] polarity, [2] irq_en.
  - 0x4 PERIOD.
  - 0x8 DUTY.
  - 0xC SCRATCH.
- Write handshake:
  - When AWVALID && WVALID && !AWREADY && !BVALID, AWREADY and WREADY pulse high together for 1 cycle.
  - Register bytes are updated per WSTRB on that edge.
  - BVALID rises the next cycle and holds until BREADY; no new write is accepted while BVALID = 1.
  - AW without W, or W without AW, waits indefinitely.
- Read handshake:
  - When ARVALID && !ARREADY && !RVALID, ARREADY pulses for 1 cycle.
  - RDATA is latched from the addressed register and RVALID rises the next cycle.
  - RDATA and RVALID hold stable until RREADY.
- Read and write channels are independent; both may complete in the same cycle.
- A read of the register written in the same cycle returns the old value.
- PWM counter (32-bit):
  - Runs only when enable = 1.
  - Counts 0..PERIOD_sh-1; wraps to 0 with period_tick = 1 in the wrap cycle.
  - Shadow registers PERIOD_sh and DUTY_sh load from PERIOD and DUTY at each wrap, and continuously while disabled. Mid-period writes therefore never glitch the output.
- pwm_out:
  - Registered: (cnt < DUTY_sh) XOR polarity, one cycle after the counter value.
  - Disabled: counter forced to 0, pwm_out = polarity, no ticks.
  - PERIOD_sh = 0: counter held at 0, pwm_out = polarity, no ticks.
  - DUTY_sh >= PERIOD_sh: pwm_out = NOT polarity continuously.
  - DUTY_sh = 0: pwm_out = polarity continuously.
- Reset mid-transaction: all handshakes abort immediately; the master must reissue.

Optional Feature:
- Macro: PWM_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - A sticky flag sets on period_tick when CTRL[2] = 1; irq = flag.
  - The flag clears on any completed AXI write to offset 0x0 (clear has priority over a same-cycle set).
  - The flag resets to 0.
  - CTRL readback is unaffected.
- Undefined: no irq port, no flag logic; CTRL[2] is storage only.

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x0, 0x4, 0x8, 0xC, reading back after each -> each read returns the identical value, BRESP = RRESP = 2'b00.
- Write 0xFFFFFFFF to 0xC with WSTRB = 4'b0101 after 0x00000000 -> readback 0x00FF00FF.
- PERIOD = 10, DUTY = 3, CTRL = 0x1 -> pwm_out repeats 3 high / 7 low, period_tick every 10 cycles; then CTRL = 0x3 -> inverted waveform.
- While running at PERIOD = 10, DUTY = 3, write DUTY = 6 mid-period -> current period still 3 high; the next period is 6 high.
- Edge cases:
  - DUTY = 12, PERIOD = 10 -> pwm_out constant 1.
  - PERIOD = 0 -> pwm_out = 0, no ticks.
  - Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA held stable; assert ARESETN low mid-hold -> VALIDs drop at once.
- PWM_IRQ_EN: CTRL = 0x5, PERIOD = 4 -> irq rises on the first tick and stays high; write CTRL = 0x5 -> irq clears, then resets on the next tick.
